// File: rtl/t07_fxp_pkg.sv
// Shared types, flag positions and saturation bounds for the team-07 fixed-point sequential unit.
package t07_fxp_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_MADD = 4'd4,
    OP_MSUB = 4'd5,
    OP_MIN  = 4'd6,
    OP_MAX  = 4'd7,
    OP_EQ   = 4'd8,
    OP_LT   = 4'd9,
    OP_LE   = 4'd10,
    OP_ABS  = 4'd11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_ACC  = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  localparam int FLG_ZERO = 0;
  localparam int FLG_OVF  = 1;
  localparam int FLG_DIVZ = 2;
  localparam int FLG_INV  = 3;

  // Bounds are returned in 64 bits; callers cast down to their own width (<= 64).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/t07_fxp_muldiv_core.sv
// Iterative unsigned engine: shift-add multiply (WIDTH steps) or restoring divide of a<<FRAC (WIDTH+FRAC steps).
module t07_fxp_muldiv_core #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 load_i,
  input  logic                 mode_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_mag_i,
  input  logic [WIDTH-1:0]     b_mag_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   mag_o
);

  localparam int QW = WIDTH + FRAC;
  localparam int CW = $clog2(QW + 1);

  logic              mode_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  dvs_q;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [QW-1:0]     q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH:0]    mul_sum, r_sh, r_sub;
  logic              r_ge;

  // Multiplier sits in the low half of p_q and is consumed LSB-first as the product shifts in.
  always_comb begin
    mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, dvs_q} : '0);
    p_d     = {mul_sum, p_q[WIDTH-1:1]};
    r_sh    = {r_q, q_q[QW-1]};
    r_sub   = r_sh - {1'b0, dvs_q};
    r_ge    = (r_sh >= {1'b0, dvs_q});
    r_d     = r_ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
    q_d     = {q_q[QW-2:0], r_ge};
    last_o  = (cnt_q == (mode_q ? CW'(QW - 1) : CW'(WIDTH - 1)));
    mag_o   = mode_q ? (2*WIDTH)'(q_d) : (p_d >> FRAC);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode_q <= 1'b0;
      cnt_q  <= '0;
      dvs_q  <= '0;
      p_q    <= '0;
      q_q    <= '0;
      r_q    <= '0;
    end else if (load_i) begin
      mode_q <= mode_i;
      cnt_q  <= '0;
      dvs_q  <= mode_i ? b_mag_i : a_mag_i;
      p_q    <= {{WIDTH{1'b0}}, b_mag_i};
      q_q    <= {a_mag_i, {FRAC{1'b0}}};
      r_q    <= '0;
    end else if (step_i) begin
      cnt_q <= cnt_q + 1'b1;
      p_q   <= p_d;
      q_q   <= q_d;
      r_q   <= r_d;
    end
  end

endmodule

// File: rtl/t07_fxp_seq_unit.sv
// Multi-cycle saturating signed fixed-point unit: FSM, sign handling, saturation and single-cycle ops.
module t07_fxp_seq_unit
  import t07_fxp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state_o
);

  localparam logic [WIDTH-1:0]   MAXV    = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0]   MINV    = WIDTH'(sat_min(WIDTH));
  localparam logic [2*WIDTH-1:0] MAG_POS = {{WIDTH{1'b0}}, MAXV};
  localparam logic [2*WIDTH-1:0] MAG_NEG = MAG_POS + (2*WIDTH)'(1);

  state_e           state_q;
  logic [3:0]       op_q, flags_q;
  logic [WIDTH-1:0] c_q, prod_q, result_q;
  logic             neg_q, prod_ovf_q, done_q;

  logic             accept, is_mul_op, is_div_op;
  logic [WIDTH-1:0] a_mag, b_mag, sc_res, sgn_res, acc_res;
  logic             sc_ovf, sc_divz, sc_inv, sgn_ovf, acc_ovf;
  logic [WIDTH:0]   addsub, acc_sum;
  logic             core_last;
  logic [2*WIDTH-1:0] core_mag;

  function automatic logic [WIDTH:0] add_sat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic sub);
    logic [WIDTH:0] s;
    s = sub ? ({x[WIDTH-1], x} - {y[WIDTH-1], y}) : ({x[WIDTH-1], x} + {y[WIDTH-1], y});
    if (s[WIDTH] != s[WIDTH-1]) return {1'b1, (s[WIDTH] ? MINV : MAXV)};
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic ovf,
                                          input logic divz, input logic inv);
    logic [3:0] f;
    f           = '0;
    f[FLG_ZERO] = (r == '0);
    f[FLG_OVF]  = ovf;
    f[FLG_DIVZ] = divz;
    f[FLG_INV]  = inv;
    return f;
  endfunction

  // Handshake: start is sampled on a rising edge only when busy=0 (IDLE or FIN); operands and op
  // are captured on that edge, busy stays high through MUL/DIV/ACC, and done pulses for exactly one
  // cycle together with the new result/flags.
  assign accept    = start && (state_q == S_IDLE || state_q == S_FIN);
  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_mag     = b[WIDTH-1] ? -b : b;
  assign is_mul_op = (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
  assign is_div_op = (op == OP_DIV) && (b != '0);

  t07_fxp_muldiv_core #(.WIDTH(WIDTH), .FRAC(FRAC)) u_core (
    .clk     (clk),
    .nrst    (nrst),
    .load_i  (accept && (is_mul_op || is_div_op)),
    .mode_i  (op == OP_DIV),
    .step_i  (state_q == S_MUL || state_q == S_DIV),
    .a_mag_i (a_mag),
    .b_mag_i (b_mag),
    .last_o  (core_last),
    .mag_o   (core_mag)
  );

  always_comb begin
    if (!neg_q) begin
      sgn_ovf = (core_mag > MAG_POS);
      sgn_res = sgn_ovf ? MAXV : core_mag[WIDTH-1:0];
    end else begin
      sgn_ovf = (core_mag > MAG_NEG);
      sgn_res = sgn_ovf ? MINV : -core_mag[WIDTH-1:0];
    end
    acc_sum = add_sat(prod_q, c_q, op_q == OP_MSUB);
    acc_ovf = acc_sum[WIDTH] | prod_ovf_q;
    acc_res = acc_sum[WIDTH-1:0];
  end

  always_comb begin
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_divz = 1'b0;
    sc_inv  = 1'b0;
    addsub  = add_sat(a, b, op == OP_SUB);
    case (op)
      OP_ADD, OP_SUB: {sc_ovf, sc_res} = addsub;
      OP_DIV: begin
        sc_divz = 1'b1;
        sc_res  = a[WIDTH-1] ? MINV : MAXV;
      end
      OP_MIN: sc_res = ($signed(a) <= $signed(b)) ? a : b;
      OP_MAX: sc_res = ($signed(a) >= $signed(b)) ? a : b;
      OP_EQ:  sc_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_LT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_LE:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) <= $signed(b)};
      OP_ABS: begin
        sc_ovf = (a == MINV);
        sc_res = sc_ovf ? MAXV : a_mag;
      end
      OP_MUL, OP_MADD, OP_MSUB: sc_res = '0;
      default: sc_inv = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      c_q        <= '0;
      neg_q      <= 1'b0;
      prod_q     <= '0;
      prod_ovf_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FIN: begin
          state_q <= S_IDLE;
          if (accept) begin
            op_q  <= op;
            c_q   <= c;
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            if (is_mul_op)      state_q <= S_MUL;
            else if (is_div_op) state_q <= S_DIV;
            else begin
              state_q  <= S_FIN;
              done_q   <= 1'b1;
              result_q <= sc_res;
              flags_q  <= mk_flags(sc_res, sc_ovf, sc_divz, sc_inv);
            end
          end
        end
        S_MUL: if (core_last) begin
          if (op_q == OP_MUL) begin
            state_q  <= S_FIN;
            done_q   <= 1'b1;
            result_q <= sgn_res;
            flags_q  <= mk_flags(sgn_res, sgn_ovf, 1'b0, 1'b0);
          end else begin
            state_q    <= S_ACC;
            prod_q     <= sgn_res;
            prod_ovf_q <= sgn_ovf;
          end
        end
        S_DIV: if (core_last) begin
          state_q  <= S_FIN;
          done_q   <= 1'b1;
          result_q <= sgn_res;
          flags_q  <= mk_flags(sgn_res, sgn_ovf, 1'b0, 1'b0);
        end
        S_ACC: begin
          state_q  <= S_FIN;
          done_q   <= 1'b1;
          result_q <= acc_res;
          flags_q  <= mk_flags(acc_res, acc_ovf, 1'b0, 1'b0);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result      = result_q;
  assign flags       = flags_q;
  assign done        = done_q;
  assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_ACC);
  assign dbg_state_o = state_q;

endmodule

// File: doc/t07_fxp_seq_unit.md
Name: t07_fxp_seq_unit

Overview:
Parametrised, multi-cycle signed fixed-point arithmetic unit (two's complement, Q(WIDTH-FRAC).FRAC), the next-generation fixed-point FPU datapath for the team-07 core.
- Adds iterative multiply, divide and fused multiply-add, with saturating arithmetic, sticky-free per-operation flags and a start/busy/done handshake.
- Sits beside the integer ALU; the CPU stalls on busy.

Parameters:
WIDTH, 32, total operand/result width in bits (>= 8)
FRAC, 16, fractional bits (1 .. WIDTH-2)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only when busy=0
op  in  4  operation code (see Behaviour)
a  in  WIDTH  operand A, signed fixed point
b  in  WIDTH  operand B, signed fixed point
c  in  WIDTH  addend for MADD/MSUB
result  out  WIDTH  registered result, held until next completion
flags  out  4  [0] zero, [1] overflow/saturated, [2] divide-by-zero, [3] invalid op
busy  out  1  high while a multi-cycle op is in progress
done  out  1  one-cycle pulse when result/flags update

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - nrst=0 forces result=0, flags=0, busy=0, done=0, state=IDLE, all internal registers 0.
  - Reset mid-operation aborts with no done pulse.
- Handshake:
  - a, b, c and op are captured on the start cycle when busy=0.
  - start while busy=1 is ignored; captured operands are unaffected.
  - done and result/flags update occur in the same cycle.
  - start may be asserted in the cycle done is high.
- Op codes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MADD (a*b+c), 5 MSUB (a*b-c), 6 MIN, 7 MAX, 8 EQ, 9 LT, 10 LE, 11 ABS. Codes 12-15 are invalid.
- States: IDLE, MUL, DIV, ACC, FIN.
  - Single-cycle ops (0,1,6-11, invalid, DIV by zero) go IDLE->FIN. done is high the cycle after start; busy stays 0.
  - MUL: IDLE->MUL for WIDTH cycles->FIN. done occurs WIDTH+1 cycles after start.
  - DIV: IDLE->DIV for WIDTH+FRAC cycles->FIN. done occurs WIDTH+FRAC+1 cycles after start.
  - MADD/MSUB: IDLE->MUL (WIDTH)->ACC (1)->FIN. done occurs WIDTH+2 cycles after start.
  - FIN->IDLE unconditionally. busy=1 in MUL/DIV/ACC.
- Arithmetic:
  - MUL/DIV operate on unsigned magnitudes (WIDTH bits; |MIN| = 2^(WIDTH-1) fits); the sign is re-applied at the end.
  - MUL: shift-add, one bit per cycle, 2*WIDTH product, >>FRAC, truncation toward zero.
  - DIV: restoring, |a|<<FRAC over WIDTH+FRAC quotient bits, truncation toward zero.
  - ADD/SUB/ACC use a WIDTH+1-bit sum.
  - Any result outside [MIN=0x80..0, MAX=0x7F..F] saturates to the nearest bound and sets flags[1].
  - MADD/MSUB saturate the product first (setting flags[1]), then add/subtract c with saturation.
  - ABS(MIN) returns MAX and sets flags[1].
- DIV by zero (b==0): result = MAX if a>=0, else MIN; flags[2]=1; single-cycle.
- Comparisons:
  - EQ/LT/LE: signed compare; result 1 or 0.
  - MIN/MAX: signed. On a tie, MIN returns a and MAX returns a.
- Invalid op: result 0, flags[3]=1, flags[0]=1.
- flags[0]=1 whenever result==0. Flags are replaced at every done (not sticky).

Decomposition:
- Package t07_fxp_pkg holds:
  - op enum;
  - state enum;
  - flag bit indices;
  - saturation helper functions sat_max/sat_min (WIDTH-generic).
- One sub-module, t07_fxp_muldiv_core: the iterative shift-add/restoring engine with load/mode/step inputs, count-done output and magnitude result. The top-level handles sign, saturation, the FSM and the single-cycle ops.

Test Plan:
- Reset then MUL a=0x00018000 (1.5), b=0x00020000 (2.0) -> busy high for 32 cycles; done exactly 33 cycles after start; result=0x00030000; flags=0.
- DIV a=0x00030000, b=0x00020000 -> done 49 cycles after start; result=0x00018000. Then DIV a=0xFFFF0000, b=0 -> done next cycle; result=0x80000000; flags[2]=1.
- ADD 0x7FFF0000+0x00020000 -> result=0x7FFFFFFF, flags[1]=1. SUB 0x00010000-0x00010000 -> result=0, flags[0]=1.
- MADD a=0xFFFF0000 (-1.0), b=0x00020000, c=0x00008000 -> done 34 cycles after start; result=0xFFFE8000 (-1.5). A start pulse issued at cycle 5 is ignored.
- MIN a=0xFFFF0000, b=0x00008000 -> 0xFFFF0000. LT with the same operands -> 1. ABS 0x80000000 -> 0x7FFFFFFF with flags[1]. op=13 -> result 0, flags=0b1001.
- Assert nrst=0 for one cycle at cycle 10 of a MUL -> outputs 0 immediately with no done. A new MUL 2.0*2.0 then completes with result 0x00040000.
